// File: rtl/icecream_order_gen.sv
// Ice-cream order generator: accepts a recipe index, holds the recipe code
// on {Sa,Sw,I,P} for HOLD_CYCLES cycles, then pulses done and counts the order.
module icecream_order_gen #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_idx,
  output logic       Sa,
  output logic       Sw,
  output logic       I,
  output logic       P,
  output logic       code_valid,
  output logic       done,
  output logic       err,
  output logic [7:0] serve_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  // Returns {valid, code}; indices 5..7 come back with valid clear.
  function automatic logic [4:0] recipe_lookup(input logic [2:0] idx);
    logic [4:0] r;
    case (idx)
      3'd0:    r = {1'b1, 4'b1100};
      3'd1:    r = {1'b1, 4'b0101};
      3'd2:    r = {1'b1, 4'b0011};
      3'd3:    r = {1'b1, 4'b0110};
      3'd4:    r = {1'b1, 4'b1010};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] code_q, code_d;
  logic       ready_q, ready_d;
  logic       cv_q, cv_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] serve_q, serve_d;
  logic [4:0] lookup_s;
  logic       handshake_s;

  // Next-state and next-output computation; outputs follow the next state.
  always_comb begin
    lookup_s    = recipe_lookup(req_idx);
    handshake_s = req_valid & ready_q;
    state_d     = state_q;
    hold_d      = hold_q;
    code_d      = code_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    serve_d     = serve_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          if (lookup_s[4]) begin
            code_d  = lookup_s[3:0];
            hold_d  = HOLD_LOAD;
            state_d = ST_DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (hold_q == 8'd0) begin
          state_d = ST_DONE;
          code_d  = 4'b0000;
          done_d  = 1'b1;
          serve_d = (serve_q == 8'hFF) ? serve_q : serve_q + 8'd1;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = 4'b0000;
        hold_d  = 8'd0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    cv_d    = (state_d == ST_DRIVE);
  end

  // State and output registers; reset wins over any order in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'd0;
      code_q  <= 4'b0000;
      ready_q <= 1'b1;
      cv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      serve_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      cv_q    <= cv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      serve_q <= serve_d;
    end
  end

  assign req_ready       = ready_q;
  assign code_valid      = cv_q;
  assign {Sa, Sw, I, P}  = code_q;
  assign done            = done_q;
  assign err             = err_q;
  assign serve_cnt       = serve_q;

endmodule
